// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for uart_tx_port: bus widths, register offsets,
// STATUS bit indices and transmit FSM state encodings.
package uart_tx_port_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] UartTxDataAddr = 2'd0;
  localparam logic [1:0] UartStatusAddr = 2'd1;
  localparam logic [1:0] UartBaudAddr   = 2'd2;
  localparam logic [1:0] UartCtrlAddr   = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with a read-first (combinational) head; pointers
// carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign count     = r_wr_ptr - r_rd_ptr;
  assign full      = (count == PTR_W'(DEPTH));
  assign empty     = (count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PTR_W-2:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, STATUS, BAUDDIV and CTRL registers.
// Optional interrupt output and CTRL register enabled by defining UART_TX_IRQ_EN.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e          r_state, w_state_n;
  logic [15:0]        r_baud;
  logic [15:0]        r_bit_cnt, w_bit_cnt_n;
  logic [2:0]         r_bit_idx, w_bit_idx_n;
  logic [7:0]         r_shift, w_shift_n;
  logic               r_tx, w_tx_n;
  logic               r_ovf;
  logic               w_pop;

  logic [7:0]         w_fifo_dout;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;

  logic               w_wr;
  logic               w_rd;
  logic [1:0]         w_reg;
  logic               w_push_req;
  logic               w_ovf_clr;
  logic               w_baud_wr;
  logic [15:0]        w_div;
  logic               w_tick;
  logic [DATA_W-1:0]  w_status;
  logic               w_unused;

  assign w_wr       = ce & we;
  assign w_rd       = ce & ~we;
  assign w_reg      = addr[3:2];
  assign w_push_req = w_wr & (w_reg == UartTxDataAddr) & sel[0];
  assign w_ovf_clr  = w_wr & (w_reg == UartStatusAddr) & sel[0] & data_in[STAT_OVF];
  assign w_baud_wr  = w_wr & (w_reg == UartBaudAddr) & (sel[1:0] == 2'b11);
  assign w_unused   = ^{addr[ADDR_W-1:4], addr[1:0], sel[3:2], data_in[DATA_W-1:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (data_in[7:0]),
    .dout  (w_fifo_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Overflow set beats a same-edge W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud <= DEFAULT_DIV;
      r_ovf  <= 1'b0;
    end else begin
      if (w_baud_wr) r_baud <= data_in[15:0];
      if (w_push_req && w_full) r_ovf <= 1'b1;
      else if (w_ovf_clr)       r_ovf <= 1'b0;
    end
  end

  // Bit timer reloads from BAUDDIV at every bit boundary.
  assign w_div  = (r_baud == 16'd0) ? 16'd1 : r_baud;
  assign w_tick = (r_bit_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_bit_idx <= w_bit_idx_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_bit_cnt_n = r_bit_cnt;
    w_bit_idx_n = r_bit_idx;
    w_shift_n   = r_shift;
    w_tx_n      = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_n = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_n   = w_fifo_dout;
          w_bit_cnt_n = w_div - 16'd1;
          w_state_n   = ST_START;
          w_tx_n      = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_n   = ST_DATA;
          w_bit_idx_n = 3'd0;
          w_bit_cnt_n = w_div - 16'd1;
          w_tx_n      = r_shift[0];
        end else begin
          w_bit_cnt_n = r_bit_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_bit_cnt_n = w_div - 16'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_n = ST_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_idx_n = r_bit_idx + 3'd1;
            w_shift_n   = r_shift >> 1;
            w_tx_n      = r_shift[1];
          end
        end else begin
          w_bit_cnt_n = r_bit_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_n   = w_fifo_dout;
            w_bit_cnt_n = w_div - 16'd1;
            w_state_n   = ST_START;
            w_tx_n      = 1'b0;
          end else begin
            w_state_n = ST_IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_bit_cnt_n = r_bit_cnt - 16'd1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  assign tx = r_tx;

  always_comb begin
    w_status                                = '0;
    w_status[STAT_BUSY]                     = (r_state != ST_IDLE);
    w_status[STAT_FULL]                     = w_full;
    w_status[STAT_EMPTY]                    = w_empty;
    w_status[STAT_OVF]                      = r_ovf;
    w_status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(w_count);
  end

`ifdef UART_TX_IRQ_EN
  logic r_ctrl_ie;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_ie <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (w_reg == UartCtrlAddr) && sel[0]) r_ctrl_ie <= data_in[0];
      r_irq <= r_ctrl_ie & w_empty & (r_state == ST_IDLE);
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    data_out = '0;
    if (w_rd) begin
      case (w_reg)
        UartStatusAddr: data_out = w_status;
        UartBaudAddr:   data_out = {{(DATA_W-16){1'b0}}, r_baud};
`ifdef UART_TX_IRQ_EN
        UartCtrlAddr:   data_out = {{(DATA_W-1){1'b0}}, r_ctrl_ie};
`endif
        default:        data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port (build with +define+UART_TX_IRQ_EN
// to include the interrupt scenario).
module tb_uart_tx_port;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int checks;
  int failures;

  uart_tx_port dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .we       (we),
    .addr     (addr),
    .sel      (sel),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line level for frame slot idx: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic bus_idle();
    ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_in = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; sel = s; data_in = d;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'h0; data_in = '0;
    #1;
    d = data_out;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h4); end
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'd434) begin failures++; $display("FAIL reset_baud got=%0d exp=434", rd); end
    bus_read(32'hC, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
    bus_read(32'h0, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL txdata_read got=%h exp=0", rd); end
    @(negedge clk);
    addr = 32'h4; ce = 1'b0; we = 1'b0;
    #1;
    checks++;
    if (data_out !== 32'h0) begin failures++; $display("FAIL read_ce0 got=%h exp=0", data_out); end
    ce = 1'b1; we = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin failures++; $display("FAIL read_we1 got=%h exp=0", data_out); end
    bus_idle();
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic        e;
    bus_write(32'h8, 32'd4, 4'b0011);
    bus_write(32'h0, 32'h55, 4'b0001);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0100) begin failures++; $display("FAIL single_count1 got=%h exp=%h", rd, 32'h100); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      e = frame_bit(8'h55, i / 4);
      checks++;
      if (tx !== e) begin failures++; $display("FAIL single_tx[%0d] got=%b exp=%b", i, tx, e); end
    end
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0005) begin failures++; $display("FAIL single_busy40 got=%h exp=%h", rd, 32'h5); end
    @(posedge clk);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin failures++; $display("FAIL single_idle41 got=%h exp=%h", rd, 32'h4); end
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_idle got=%b exp=1", tx); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  bytes [3];
    logic        e;
    bytes[0] = 8'hA1; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
    bus_write(32'h0, {24'h0, bytes[0]}, 4'b0001);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i < 2) begin
        ce = 1'b1; we = 1'b1; addr = 32'h0; sel = 4'b0001; data_in = {24'h0, bytes[i+1]};
      end else begin
        bus_idle();
      end
      @(posedge clk);
      #1;
      e = frame_bit(bytes[i / 40], (i % 40) / 4);
      checks++;
      if (tx !== e) begin failures++; $display("FAIL b2b_tx[%0d] got=%b exp=%b", i, tx, e); end
    end
    @(posedge clk);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin failures++; $display("FAIL b2b_empty got=%h exp=%h", rd, 32'h4); end
  endtask

  task automatic test_baud_change();
    logic [31:0] rd;
    logic        e;
    int          slot;
    bus_write(32'h8, 32'd2, 4'b0011);
    bus_write(32'h0, 32'h3C, 4'b0001);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 9) begin
        ce = 1'b1; we = 1'b1; addr = 32'h8; sel = 4'b0011; data_in = 32'd8;
      end else begin
        bus_idle();
      end
      @(posedge clk);
      #1;
      slot = (i < 10) ? (i / 2) : (5 + (i - 10) / 8);
      e = frame_bit(8'h3C, slot);
      checks++;
      if (tx !== e) begin failures++; $display("FAIL baud_tx[%0d] got=%b exp=%b", i, tx, e); end
    end
    @(posedge clk);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin failures++; $display("FAIL baud_idle got=%h exp=%h", rd, 32'h4); end
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'd8) begin failures++; $display("FAIL baud_read got=%0d exp=8", rd); end
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd;
    bus_write(32'h8, 32'd4, 4'b0011);
    bus_write(32'hC, 32'd1, 4'b0001);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_idle got=%b exp=1", irq); end
    bus_read(32'hC, rd);
    checks++;
    if (rd !== 32'd1) begin failures++; $display("FAIL ctrl_read got=%h exp=1", rd); end
    bus_write(32'h0, 32'h33, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_busy got=%b exp=0", irq); end
    repeat (39) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_frame_end got=%b exp=0", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_done got=%b exp=1", irq); end
    bus_write(32'hC, 32'd0, 4'b0001);
  endtask
`endif

  task automatic test_overflow_and_reset();
    logic [31:0] rd;
    bus_write(32'h8, 32'hFFFF, 4'b0011);
    bus_write(32'h0, 32'h11, 4'b0001);
    @(posedge clk);
    for (int i = 0; i < 16; i++) bus_write(32'h0, i, 4'b0001);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_1003) begin failures++; $display("FAIL ovf_full got=%h exp=%h", rd, 32'h1003); end
    bus_write(32'h0, 32'hEE, 4'b0001);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_100B) begin failures++; $display("FAIL ovf_set got=%h exp=%h", rd, 32'h100B); end
    bus_write(32'h4, 32'h8, 4'b0001);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_1003) begin failures++; $display("FAIL ovf_w1c got=%h exp=%h", rd, 32'h1003); end
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL midframe_tx got=%b exp=0", tx); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", tx); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin failures++; $display("FAIL rst_status got=%h exp=%h", rd, 32'h4); end
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'd434) begin failures++; $display("FAIL rst_baud got=%0d exp=434", rd); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_idle();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_baud_change();
`ifdef UART_TX_IRQ_EN
    test_irq();
`endif
    test_overflow_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
